hub75_bcm_sched: RTL and testbench

Parametrised Binary Code Modulation sequencer for one HUB75 row. It sits between the frame/row scanner, the pixel shifter and the blanking generator. It walks the bit-planes of one row in a configurable order and skips any plane that the runtime mask disables. For each enabled plane it issues shift, latch and blank handshakes, with programmable pre-latch, latch and post-latch timing and a parametrised timer width.

---
 rtl/hub75_bcm_sched.sv | 165 ++++++++++++++++
 tb/tb_hub75_bcm_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_sched.sv
// BCM bit-plane sequencer for one HUB75 row: walks enabled planes in the chosen
// order and drives shift / latch / blank handshakes with programmable latch timing.
module hub75_bcm_sched #(
    parameter int N_ROWS       = 32,
    parameter int N_PLANES     = 10,
    parameter int TW           = 8,
    parameter int LOG_N_ROWS   = $clog2(N_ROWS),
    parameter int LOG_N_PLANES = $clog2(N_PLANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [LOG_N_ROWS-1:0]   hub75_addr,
    output logic                    hub75_le,
    output logic [N_PLANES-1:0]     shift_plane,
    output logic                    shift_go,
    input  logic                    shift_rdy,
    output logic [N_PLANES-1:0]     blank_plane,
    output logic                    blank_go,
    input  logic                    blank_rdy,
    input  logic [LOG_N_ROWS-1:0]   ctrl_row,
    input  logic                    ctrl_go,
    output logic                    ctrl_rdy,
    input  logic [N_PLANES-1:0]     cfg_plane_mask,
    input  logic                    cfg_msb_first,
    input  logic [TW-1:0]           cfg_pre_latch_len,
    input  logic [TW-1:0]           cfg_latch_len,
    input  logic [TW-1:0]           cfg_post_latch_len,
    output logic [LOG_N_PLANES:0]   stat_planes_done
);

    typedef enum logic [2:0] {
        IDLE, SCAN, SHIFT, WAIT, PRE, LATCH, POST, BLANK
    } state_t;

    localparam logic [LOG_N_PLANES-1:0] IDX_LAST = LOG_N_PLANES'(N_PLANES - 1);

    state_t                  state, state_nxt;
    logic [LOG_N_PLANES-1:0] idx, idx_nxt, idx_step;
    logic [LOG_N_ROWS-1:0]   row_q;
    logic [N_PLANES-1:0]     mask_q;
    logic                    msb_q;
    logic [TW-1:0]           timer;
    logic                    idx_last;
    logic                    accept;
    logic [N_PLANES-1:0]     plane_oh;

    assign accept   = (state == IDLE) && ctrl_go;
    assign idx_last = msb_q ? (idx == '0) : (idx == IDX_LAST);
    assign idx_step = msb_q ? (idx - 1'b1) : (idx + 1'b1);

    always_comb begin
        plane_oh      = '0;
        plane_oh[idx] = 1'b1;
    end

    assign ctrl_rdy    = (state == IDLE);
    assign shift_go    = (state == SHIFT);
    assign blank_go    = (state == BLANK);
    assign shift_plane = (state == IDLE) ? '0 : plane_oh;
    assign blank_plane = shift_plane;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (ctrl_go) begin
                    state_nxt = SCAN;
                    idx_nxt   = cfg_msb_first ? IDX_LAST : '0;
                end
            end
            SCAN: begin
                if (mask_q[idx]) begin
                    state_nxt = SHIFT;
                end else if (idx_last) begin
                    state_nxt = IDLE;
                end else begin
                    idx_nxt = idx_step;
                end
            end
            SHIFT: state_nxt = WAIT;
            WAIT: begin
                if (shift_rdy && blank_rdy) state_nxt = PRE;
            end
            PRE: begin
                if (timer == '0) state_nxt = LATCH;
            end
            LATCH: begin
                if (timer == '0) state_nxt = POST;
            end
            POST: begin
                if (timer == '0) state_nxt = BLANK;
            end
            BLANK: begin
                if (idx_last) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SCAN;
                    idx_nxt   = idx_step;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sequence context is captured once per accepted go so mid-sequence config changes are inert.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q  <= '0;
            mask_q <= '0;
            msb_q  <= 1'b0;
        end else if (accept) begin
            row_q  <= ctrl_row;
            mask_q <= cfg_plane_mask;
            msb_q  <= cfg_msb_first;
        end
    end

    // Phase timer reloads on every phase change, so lengths are sampled at phase entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (state_nxt != state) begin
            case (state_nxt)
                PRE:     timer <= cfg_pre_latch_len;
                LATCH:   timer <= cfg_latch_len;
                POST:    timer <= cfg_post_latch_len;
                default: timer <= timer;
            endcase
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_planes_done <= '0;
        end else if (accept) begin
            stat_planes_done <= '0;
        end else if (state == BLANK) begin
            stat_planes_done <= stat_planes_done + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hub75_le   <= 1'b0;
            hub75_addr <= '0;
        end else begin
            hub75_le <= (state == LATCH);
            if (state == LATCH) hub75_addr <= row_q;
        end
    end

endmodule

// File: tb/tb_hub75_bcm_sched.sv
// Scoreboard bench for hub75_bcm_sched: a list-based plane-order model feeds
// expectation queues that a cycle-counting monitor consumes.
module tb_hub75_bcm_sched;

    localparam int NP = 10;
    localparam int NR = 32;
    localparam int TW = 8;
    localparam int LR = 5;
    localparam int LP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [LR-1:0] hub75_addr;
    logic          hub75_le;
    logic [NP-1:0] shift_plane, blank_plane, cfg_plane_mask;
    logic          shift_go, shift_rdy, blank_go, blank_rdy;
    logic [LR-1:0] ctrl_row;
    logic          ctrl_go, ctrl_rdy, cfg_msb_first;
    logic [TW-1:0] cfg_pre_latch_len, cfg_latch_len, cfg_post_latch_len;
    logic [LP:0]   stat_planes_done;

    hub75_bcm_sched #(.N_ROWS(NR), .N_PLANES(NP), .TW(TW)) dut (
        .clk(clk), .rst(rst),
        .hub75_addr(hub75_addr), .hub75_le(hub75_le),
        .shift_plane(shift_plane), .shift_go(shift_go), .shift_rdy(shift_rdy),
        .blank_plane(blank_plane), .blank_go(blank_go), .blank_rdy(blank_rdy),
        .ctrl_row(ctrl_row), .ctrl_go(ctrl_go), .ctrl_rdy(ctrl_rdy),
        .cfg_plane_mask(cfg_plane_mask), .cfg_msb_first(cfg_msb_first),
        .cfg_pre_latch_len(cfg_pre_latch_len), .cfg_latch_len(cfg_latch_len),
        .cfg_post_latch_len(cfg_post_latch_len),
        .stat_planes_done(stat_planes_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NP-1:0] oh;
        int            skip;
        logic [LR-1:0] row;
        int            pre, lat, post;
    } plane_t;
    typedef struct { int n; int tail; } seq_t;

    plane_t exp_q[$];
    seq_t   seq_q[$];
    int     n_tests = 0, n_fail = 0;
    int     sdly = 0, bdly = 0;
    bit     s_rand = 1'b0;
    logic [LR-1:0] last_row = '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: enabled planes in scan order, each with the count of disabled planes scanned before it.
    function automatic void model(input logic [NP-1:0] m, input bit msb, input logic [LR-1:0] row,
                                  input int pre, input int lat, input int post);
        int     skip = 0;
        int     n = 0;
        plane_t p;
        seq_t   s;
        for (int i = 0; i < NP; i++) begin
            int b = msb ? NP - 1 - i : i;
            if (m[b]) begin
                p.oh = '0; p.oh[b] = 1'b1;
                p.skip = skip; p.row = row; p.pre = pre; p.lat = lat; p.post = post;
                exp_q.push_back(p);
                skip = 0;
                n++;
            end else begin
                skip++;
            end
        end
        s.n = n; s.tail = skip;
        seq_q.push_back(s);
    endfunction

    // Shifter/blanker responders: rdy drops right after a go and recovers after a chosen delay.
    initial begin
        int sb = 0, bb = 0;
        bit g, bg;
        shift_rdy = 1'b1; blank_rdy = 1'b1;
        forever begin
            @(negedge clk);
            g = shift_go; bg = blank_go;
            #1;
            if (sb > 0) sb--;
            if (bb > 0) bb--;
            if (g)  sb = s_rand ? int'($urandom_range(1, 4)) : sdly;
            if (bg) bb = s_rand ? int'($urandom_range(0, 3)) : bdly;
            shift_rdy = (sb == 0);
            blank_rdy = (bb == 0);
        end
    end

    // Monitor: inputs seen at negedge m are the ones the DUT sampled at the end of cycle m-1.
    int     cyc = 0, ref_cyc = 0, shift_cyc = 0, exp_le_rise = -1, le_start = 0, exp_blank = -1;
    bit     armed, have_seq, le_prev, rdy_prev;
    plane_t cur;
    seq_t   cur_seq;

    function void flush();
        armed = 1'b0; have_seq = 1'b0; le_prev = 1'b0; rdy_prev = 1'b1;
        exp_le_rise = -1; exp_blank = -1; ref_cyc = cyc;
    endfunction

    initial begin
        flush();
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                flush();
                continue;
            end
            if (ctrl_go && rdy_prev) begin
                if (seq_q.size() == 0) check("go_accept_unexpected", 1, 0);
                else begin
                    cur_seq = seq_q.pop_front();
                    have_seq = 1'b1;
                    ref_cyc = cyc - 1;
                end
            end
            if (shift_go) begin
                if (exp_q.size() == 0) check("shift_go_unexpected", 1, 0);
                else begin
                    cur = exp_q.pop_front();
                    check("shift_go_cycle", cyc, ref_cyc + cur.skip + 2);
                    check("shift_plane", shift_plane, cur.oh);
                    check("blank_plane", blank_plane, cur.oh);
                    shift_cyc = cyc;
                    armed = 1'b1;
                end
            end else if (armed && cyc >= shift_cyc + 2 && shift_rdy && blank_rdy) begin
                exp_le_rise = cyc + cur.pre + 2;
                armed = 1'b0;
            end
            if (hub75_le && !le_prev) begin
                check("le_rise_cycle", cyc, exp_le_rise);
                check("addr_at_le", hub75_addr, cur.row);
                exp_le_rise = -1;
                le_start = cyc;
            end
            if (!hub75_le && le_prev) begin
                check("le_width", cyc - le_start, cur.lat + 1);
                exp_blank = cyc + cur.post;
            end
            if (blank_go) begin
                check("blank_go_cycle", cyc, exp_blank);
                check("blank_plane_at_blank", blank_plane, cur.oh);
                ref_cyc = cyc;
                exp_blank = -1;
            end
            if (ctrl_rdy && !rdy_prev) begin
                if (!have_seq) check("rdy_rise_unexpected", 1, 0);
                else begin
                    check("rdy_return_cycle", cyc, ref_cyc + cur_seq.tail + 1);
                    check("planes_done", stat_planes_done, cur_seq.n);
                    check("idle_planes_zero", shift_plane | blank_plane, 0);
                    have_seq = 1'b0;
                end
            end
            le_prev = hub75_le;
            rdy_prev = ctrl_rdy;
        end
    end

    task automatic wait_rdy();
        int k = 0;
        do begin
            @(negedge clk);
            if (!ctrl_rdy) begin
                #1;
                cfg_plane_mask = NP'($urandom);
                cfg_msb_first  = 1'($urandom);
                ctrl_row       = LR'($urandom);
            end
            k++;
        end while (!ctrl_rdy && k < 5000);
        if (!ctrl_rdy) check("wait_rdy_timeout", 0, 1);
    endtask

    task automatic run_seq(input logic [NP-1:0] m, input bit msb, input logic [LR-1:0] row,
                           input int pre, input int lat, input int post, input bit wait_done);
        wait_rdy();
        #1;
        cfg_plane_mask     = m;
        cfg_msb_first      = msb;
        ctrl_row           = row;
        cfg_pre_latch_len  = TW'(pre);
        cfg_latch_len      = TW'(lat);
        cfg_post_latch_len = TW'(post);
        ctrl_go            = 1'b1;
        model(m, msb, row, pre, lat, post);
        if (m != '0) last_row = row;
        @(negedge clk);
        #1 ctrl_go = 1'b0;
        if (wait_done) wait_rdy();
    endtask

    initial begin
        #3_000_000;
        n_fail++;
        $display("FAIL watchdog: time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b0; ctrl_go = 1'b0; ctrl_row = '0; cfg_plane_mask = '0; cfg_msb_first = 1'b0;
        cfg_pre_latch_len = '0; cfg_latch_len = '0; cfg_post_latch_len = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_ctrl_rdy", ctrl_rdy, 1);
        check("rst_le", hub75_le, 0);
        check("rst_addr", hub75_addr, 0);
        check("rst_shift_go", shift_go, 0);
        check("rst_blank_go", blank_go, 0);
        check("rst_shift_plane", shift_plane, 0);
        check("rst_blank_plane", blank_plane, 0);
        check("rst_stat", stat_planes_done, 0);
        @(negedge clk); @(negedge clk);
        #1 rst = 1'b0;

        sdly = 0; bdly = 0;
        run_seq(10'h3FF, 1'b0, 5'd5, 0, 0, 0, 1'b1);
        run_seq(10'h205, 1'b1, 5'd17, 0, 0, 0, 1'b1);
        sdly = 1; bdly = 1;
        run_seq(10'h0C3, 1'b0, 5'd7, 3, 1, 2, 1'b1);
        run_seq(10'h201, 1'b1, 5'd3, 0, 255, 0, 1'b1);
        sdly = 20;
        run_seq(10'h010, 1'b0, 5'd12, 2, 0, 1, 1'b1);
        sdly = 1;

        run_seq(10'h000, 1'b0, 5'd21, 0, 0, 0, 1'b0);
        ctrl_row = 5'd9; ctrl_go = 1'b1;
        @(negedge clk);
        #1 ctrl_go = 1'b0;
        wait_rdy();
        check("addr_hold_busy_go", hub75_addr, last_row);

        run_seq(10'h003, 1'b0, 5'd1, 0, 0, 0, 1'b0);
        run_seq(10'h100, 1'b1, 5'd2, 1, 0, 0, 1'b0);
        run_seq(10'h000, 1'b1, 5'd4, 0, 0, 0, 1'b0);
        run_seq(10'h204, 1'b0, 5'd8, 0, 1, 0, 1'b1);

        s_rand = 1'b1;
        for (int i = 0; i < 14; i++) begin
            logic [NP-1:0] m;
            int lat;
            m = NP'($urandom);
            if (i % 6 == 5) m = '0;
            lat = (i == 7) ? 40 : int'($urandom_range(0, 4));
            run_seq(m, 1'($urandom), LR'($urandom), int'($urandom_range(0, 4)), lat,
                    int'($urandom_range(0, 4)), 1'($urandom));
        end
        s_rand = 1'b0;

        run_seq(10'h00F, 1'b0, 5'd6, 1, 10, 1, 1'b0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!hub75_le && k < 200);
        check("le_seen_before_reset", hub75_le, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_le", hub75_le, 0);
        check("arst_shift_plane", shift_plane, 0);
        check("arst_blank_plane", blank_plane, 0);
        check("arst_ctrl_rdy", ctrl_rdy, 1);
        check("arst_addr", hub75_addr, 0);
        check("arst_stat", stat_planes_done, 0);
        exp_q.delete();
        seq_q.delete();
        last_row = '0;
        @(negedge clk); @(negedge clk);
        #1 rst = 1'b0;
        run_seq(10'h081, 1'b1, 5'd30, 0, 2, 0, 1'b1);

        repeat (3) @(negedge clk);
        check("exp_planes_drained", exp_q.size(), 0);
        check("exp_seqs_drained", seq_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
